// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM,
    BRANCH, JAL, JALR, LUI, TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_ALU_ALIGN}    pc_src_t;
  typedef enum logic [1:0] {A_PC, A_RS1, A_OLDPC}               a_sel_t;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR}               b_sel_t;
  typedef enum logic [1:0] {WB_ALUOUT, WB_MDR, WB_PC, WB_IMM}   wb_sel_t;

  // ALU-control-ROM addresses, {funct7[5], funct3} encoding
  localparam logic [3:0] ADDR_ADD  = 4'd0;
  localparam logic [3:0] ADDR_SUB  = 4'd8;
  localparam logic [3:0] ADDR_SLT  = 4'd2;
  localparam logic [3:0] ADDR_SLTU = 4'd3;

endpackage

// File: rtl/multicycle_ctrl_branch_eval.sv
// Branch compare selection and taken decision from funct3 and ALU flags.
module branch_eval
  import ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_alu_zero,
  input  logic       i_alu_lsb,
  output logic [3:0] o_alu_addr,
  output logic       o_taken
);

  logic w_cond;

  // funct3[2:1] picks the compare op, funct3[0] inverts the sense
  always_comb begin
    o_alu_addr = ADDR_SUB;
    w_cond     = 1'b0;
    o_taken    = 1'b0;
    case (i_funct3[2:1])
      2'b00: begin o_alu_addr = ADDR_SUB;  w_cond = i_alu_zero; end
      2'b10: begin o_alu_addr = ADDR_SLT;  w_cond = i_alu_lsb;  end
      2'b11: begin o_alu_addr = ADDR_SLTU; w_cond = i_alu_lsb;  end
      default: ; // funct3 2/3 never reach BRANCH (trapped in decode)
    endcase
    if (i_funct3[2:1] != 2'b01) o_taken = w_cond ^ i_funct3[0];
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FSM, datapath controls, retire counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W   = 32,
  parameter int ALU_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  alu_zero,
  input  logic                  alu_lsb,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_sel,
  output logic                  ir_write,
  output logic                  mdr_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic [1:0]            a_sel,
  output logic [1:0]            b_sel,
  output logic [ALU_ADDR_W-1:0] alu_addr,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  instr_retired,
  output logic [RETIRE_W-1:0]   retire_count,
  output logic                  illegal_instr
);

  state_t              r_state, w_next;
  logic [RETIRE_W-1:0] r_retire_count;
  logic                r_illegal;
  logic                w_r_legal, w_retire, w_taken;
  logic [3:0]          w_br_addr;

  branch_eval u_branch_eval (
    .i_funct3   (funct3),
    .i_alu_zero (alu_zero),
    .i_alu_lsb  (alu_lsb),
    .o_alu_addr (w_br_addr),
    .o_taken    (w_taken)
  );

  // Only ADD/SLL/.../AND plus SUB and SRA are legal R-type encodings
  assign w_r_legal = (funct7 == 7'h00) ||
                     (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:               w_next = w_r_legal ? EXEC : TRAP;
          OP_I:               w_next = EXEC;
          OP_LOAD, OP_STORE:  w_next = MEM_ADDR;
          OP_BRANCH:          w_next = (funct3[2:1] == 2'b01) ? TRAP : BRANCH;
          OP_JAL:             w_next = JAL;
          OP_JALR:            w_next = JALR;
          OP_LUI:             w_next = LUI;
          OP_AUIPC:           w_next = WB_ALU;
          default:            w_next = TRAP;
        endcase
      end
      EXEC:     w_next = WB_ALU;
      MEM_ADDR: w_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) w_next = WB_MEM;
      MEM_WR:   if (mem_ready) w_next = FETCH;
      WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI: w_next = FETCH;
      TRAP:     w_next = TRAP;
      default:  w_next = FETCH;
    endcase
  end

  // Retire is any return to FETCH from another state
  assign w_retire = !rst && (r_state != FETCH) && (w_next == FETCH);

  // Output decode; reset forces everything low without waiting for a clock
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_ALU;
    a_sel     = A_PC;
    b_sel     = B_RS2;
    alu_addr  = ALU_ADDR_W'(ADDR_ADD);
    reg_write = 1'b0;
    wb_sel    = WB_ALUOUT;
    if (!rst) begin
      case (r_state)
        FETCH: begin
          mem_req  = 1'b1;
          b_sel    = B_FOUR;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: begin
          a_sel = A_OLDPC;
          b_sel = B_IMM;
        end
        EXEC: begin
          a_sel = A_RS1;
          if (opcode == OP_R) begin
            b_sel    = B_RS2;
            alu_addr = ALU_ADDR_W'({funct7[5], funct3});
          end else begin
            b_sel    = B_IMM;
            alu_addr = ALU_ADDR_W'({(funct3 == 3'd5) & funct7[5], funct3});
          end
        end
        MEM_ADDR: begin
          a_sel = A_RS1;
          b_sel = B_IMM;
        end
        MEM_RD: begin
          mem_req   = 1'b1;
          addr_sel  = 1'b1;
          mdr_write = mem_ready;
        end
        MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
        end
        WB_ALU: begin reg_write = 1'b1; wb_sel = WB_ALUOUT; end
        WB_MEM: begin reg_write = 1'b1; wb_sel = WB_MDR;    end
        BRANCH: begin
          a_sel    = A_RS1;
          b_sel    = B_RS2;
          alu_addr = ALU_ADDR_W'(w_br_addr);
          pc_write = w_taken;
          pc_src   = PC_ALUOUT;
        end
        JAL: begin
          reg_write = 1'b1;
          wb_sel    = WB_PC;
          pc_write  = 1'b1;
          pc_src    = PC_ALUOUT;
        end
        JALR: begin
          a_sel     = A_RS1;
          b_sel     = B_IMM;
          pc_write  = 1'b1;
          pc_src    = PC_ALU_ALIGN;
          reg_write = 1'b1;
          wb_sel    = WB_PC;
        end
        LUI: begin reg_write = 1'b1; wb_sel = WB_IMM; end
        default: ;
      endcase
    end
  end

  // Retire counter (wraps) and sticky illegal-instruction flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_count <= '0;
      r_illegal      <= 1'b0;
    end else begin
      if (w_retire)       r_retire_count <= r_retire_count + RETIRE_W'(1);
      if (w_next == TRAP) r_illegal      <= 1'b1;
    end
  end

  assign instr_retired = w_retire;
  assign retire_count  = r_retire_count;
  assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second 2-bit-counter instance checks wrap.
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP  = 7'b1100111;
  localparam logic [6:0] LUI_OP = 7'b0110111;
  localparam logic [6:0] AUI_OP = 7'b0010111;

  logic       clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic       alu_zero = 1'b0, alu_lsb = 1'b0, mem_ready = 1'b0;

  logic        mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write;
  logic [1:0]  pc_src, a_sel, b_sel, wb_sel;
  logic [3:0]  alu_addr;
  logic        reg_write, instr_retired, illegal_instr;
  logic [31:0] retire_count;

  logic        s_mem_req, s_mem_we, s_addr_sel, s_ir_write, s_mdr_write, s_pc_write;
  logic [1:0]  s_pc_src, s_a_sel, s_b_sel, s_wb_sel;
  logic [3:0]  s_alu_addr;
  logic        s_reg_write, s_instr_retired, s_illegal_instr;
  logic [1:0]  s_retire_count;

  multicycle_ctrl #(.RETIRE_W(32), .ALU_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src), .a_sel(a_sel),
    .b_sel(b_sel), .alu_addr(alu_addr), .reg_write(reg_write), .wb_sel(wb_sel),
    .instr_retired(instr_retired), .retire_count(retire_count),
    .illegal_instr(illegal_instr)
  );

  multicycle_ctrl #(.RETIRE_W(2), .ALU_ADDR_W(4)) dut_small (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .addr_sel(s_addr_sel),
    .ir_write(s_ir_write), .mdr_write(s_mdr_write), .pc_write(s_pc_write),
    .pc_src(s_pc_src), .a_sel(s_a_sel), .b_sel(s_b_sel), .alu_addr(s_alu_addr),
    .reg_write(s_reg_write), .wb_sel(s_wb_sel), .instr_retired(s_instr_retired),
    .retire_count(s_retire_count), .illegal_instr(s_illegal_instr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Fetch with immediate ready, pass decode; returns at start of third state
  task automatic fd(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
    mem_ready = 1'b1; nxt();
    mem_ready = 1'b0; nxt();
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_b_sel", 32'(b_sel), 0);
    chk("rst_count", retire_count, 0);
    chk("rst_illegal", 32'(illegal_instr), 0);
    rst = 1'b0;

    // ADD, ready on first fetch cycle
    opcode = R_OP; funct3 = 3'd0; funct7 = 7'h00; mem_ready = 1'b1; #1;
    chk("add_fetch_req", 32'(mem_req), 1);
    chk("add_fetch_irw", 32'(ir_write), 1);
    chk("add_fetch_pcw", 32'(pc_write), 1);
    chk("add_fetch_bsel", 32'(b_sel), 2);
    nxt(); mem_ready = 1'b0; #1;
    chk("add_dec_asel", 32'(a_sel), 2);
    chk("add_dec_req", 32'(mem_req), 0);
    nxt(); #1;
    chk("add_exec_alu", 32'(alu_addr), 0);
    chk("add_exec_asel", 32'(a_sel), 1);
    chk("add_exec_ret", 32'(instr_retired), 0);
    nxt(); #1;
    chk("add_wb_regw", 32'(reg_write), 1);
    chk("add_wb_ret", 32'(instr_retired), 1);
    chk("add_wb_count", retire_count, 0);
    nxt(); #1;
    chk("add_count", retire_count, 1);
    chk("add_after_regw", 32'(reg_write), 0);

    // SRAI, ready after 3 wait cycles
    opcode = I_OP; funct3 = 3'd5; funct7 = 7'h20;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      chk("srai_req", 32'(mem_req), 1);
      chk("srai_irw", 32'(ir_write), 32'(i == 3));
      nxt();
    end
    mem_ready = 1'b0;
    nxt(); #1;
    chk("srai_alu", 32'(alu_addr), 13);
    chk("srai_bsel", 32'(b_sel), 1);
    nxt(); #1;
    chk("srai_ret", 32'(instr_retired), 1);
    nxt(); #1;
    chk("srai_count", retire_count, 2);

    // load, 2 wait cycles; mem_ready held high in DECODE/MEM_ADDR is ignored
    opcode = LD_OP; funct3 = 3'd2; funct7 = 7'h00; mem_ready = 1'b1;
    nxt(); #1;
    chk("ld_dec_mdrw", 32'(mdr_write), 0);
    nxt(); #1;
    chk("ld_addr_req", 32'(mem_req), 0);
    chk("ld_addr_asel", 32'(a_sel), 1);
    chk("ld_addr_bsel", 32'(b_sel), 1);
    nxt();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      chk("ld_rd_req", 32'(mem_req), 1);
      chk("ld_rd_addrsel", 32'(addr_sel), 1);
      chk("ld_rd_mdrw", 32'(mdr_write), 32'(i == 2));
      nxt();
    end
    mem_ready = 1'b0; #1;
    chk("ld_wb_regw", 32'(reg_write), 1);
    chk("ld_wb_sel", 32'(wb_sel), 1);
    chk("ld_wb_ret", 32'(instr_retired), 1);
    nxt(); #1;
    chk("ld_count", retire_count, 3);
    chk("small_count_ones", 32'(s_retire_count), 3);

    // store, 2 wait cycles
    fd(ST_OP, 3'd2, 7'h00);
    nxt();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      chk("st_we", 32'(mem_we), 1);
      chk("st_regw", 32'(reg_write), 0);
      chk("st_ret", 32'(instr_retired), 32'(i == 2));
      nxt();
    end
    mem_ready = 1'b0; #1;
    chk("st_count", retire_count, 4);
    chk("small_count_wrap", 32'(s_retire_count), 0);

    // BLTU taken
    alu_lsb = 1'b1;
    fd(BR_OP, 3'd6, 7'h00); #1;
    chk("bltu_alu", 32'(alu_addr), 3);
    chk("bltu_pcw", 32'(pc_write), 1);
    chk("bltu_pcsrc", 32'(pc_src), 1);
    chk("bltu_ret", 32'(instr_retired), 1);
    nxt();

    // BNE not taken (operands equal)
    alu_lsb = 1'b0; alu_zero = 1'b1;
    fd(BR_OP, 3'd1, 7'h00); #1;
    chk("bne_alu", 32'(alu_addr), 8);
    chk("bne_pcw", 32'(pc_write), 0);
    chk("bne_ret", 32'(instr_retired), 1);
    nxt(); alu_zero = 1'b0; #1;
    chk("br_count", retire_count, 6);

    fd(JAL_OP, 3'd0, 7'h00); #1;
    chk("jal_pcsrc", 32'(pc_src), 1);
    chk("jal_wbsel", 32'(wb_sel), 2);
    chk("jal_pcw", 32'(pc_write), 1);
    nxt();
    fd(JR_OP, 3'd0, 7'h00); #1;
    chk("jalr_pcsrc", 32'(pc_src), 2);
    chk("jalr_asel", 32'(a_sel), 1);
    chk("jalr_wbsel", 32'(wb_sel), 2);
    chk("jalr_regw", 32'(reg_write), 1);
    nxt();
    fd(LUI_OP, 3'd0, 7'h00); #1;
    chk("lui_wbsel", 32'(wb_sel), 3);
    chk("lui_regw", 32'(reg_write), 1);
    nxt();
    fd(AUI_OP, 3'd0, 7'h00); #1;
    chk("auipc_wbsel", 32'(wb_sel), 0);
    chk("auipc_ret", 32'(instr_retired), 1);
    nxt(); #1;
    chk("misc_count", retire_count, 10);

    // unknown opcode traps
    fd(7'h7F, 3'd0, 7'h00); #1;
    chk("trap_illegal", 32'(illegal_instr), 1);
    chk("trap_req", 32'(mem_req), 0);
    chk("trap_ret", 32'(instr_retired), 0);
    repeat (3) nxt();
    mem_ready = 1'b1; #1;
    chk("trap_stay_req", 32'(mem_req), 0);
    chk("trap_sticky", 32'(illegal_instr), 1);
    chk("trap_count", retire_count, 10);
    rst = 1'b1; #1;
    chk("trap_rst_illegal", 32'(illegal_instr), 0);
    nxt(); rst = 1'b0;

    // R-type funct7=0x20 funct3=1 is illegal
    fd(R_OP, 3'd1, 7'h20); #1;
    chk("rbad_illegal", 32'(illegal_instr), 1);
    nxt(); #1;
    chk("rbad_req", 32'(mem_req), 0);
    chk("rbad_count", retire_count, 0);
    rst = 1'b1; nxt(); rst = 1'b0;

    // SUB is the legal funct7=0x20 case
    fd(R_OP, 3'd0, 7'h20); #1;
    chk("sub_alu", 32'(alu_addr), 8);
    nxt(); nxt(); #1;
    chk("sub_count", retire_count, 1);

    // async reset in the middle of a read request
    fd(LD_OP, 3'd2, 7'h00);
    nxt(); #1;
    chk("rdrst_req_before", 32'(mem_req), 1);
    #2 rst = 1'b1; #1;
    chk("rdrst_req_async", 32'(mem_req), 0);
    chk("rdrst_addrsel", 32'(addr_sel), 0);
    chk("rdrst_count", retire_count, 0);
    nxt(); rst = 1'b0; #1;
    chk("rdrst_fetch_req", 32'(mem_req), 1);
    chk("rdrst_fetch_bsel", 32'(b_sel), 2);
    chk("rdrst_fetch_count", retire_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
